// File: rtl/qam_pkg.sv
// qam_pkg: IQ field layout and BPSK symbol constants shared by the QAM-2 mapper and demapper
package qam_pkg;
  localparam int IQ_W  = 12;
  localparam int I_LSB = 0;
  localparam int Q_LSB = IQ_W;
  localparam logic [31:0] QAM2_POS = 32'h0000_0003;
  localparam logic [31:0] QAM2_NEG = 32'h0000_0FFF;
endpackage

// File: rtl/qam_demod_fifo.sv
// qam_demod_fifo: 2-entry FIFO; head register keeps its last word when the buffer drains
module qam_demod_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d, n;
  logic do_pop, do_push;
  always_comb begin
    do_pop  = pop & (cnt_q != 2'd0);
    do_push = push & ((cnt_q != 2'd2) | do_pop);
    n       = cnt_q - {1'b0, do_pop};
    head_d  = (do_push && n == 2'd0) ? din : (do_pop && cnt_q == 2'd2) ? tail_q : head_q;
    tail_d  = (do_push && n == 2'd1) ? din : tail_q;
    cnt_d   = clear ? 2'd0 : n + {1'b0, do_push};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout  = head_q;
  assign full  = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/qam_2_demod.sv
// qam_2_demod: BPSK hard-decision slicer with erasure flagging, bit packing and buffered word output
module qam_2_demod import qam_pkg::*; #(
  parameter int IQ_WIDTH  = IQ_W,
  parameter int OUT_WIDTH = 8,
  parameter int LSB_FIRST = 0,
  parameter int THRESH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [31:0]          signal_in,
  input  logic                 signal_valid,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 overflow,
  output logic [15:0]          erasure_count,
  output logic                 ready
);
  localparam int CW = OUT_WIDTH > 1 ? $clog2(OUT_WIDTH) : 1;
  localparam logic [IQ_WIDTH:0] TH = (IQ_WIDTH+1)'(THRESH);
  logic [IQ_WIDTH-1:0] i_s;
  logic signed [IQ_WIDTH:0] i_x;
  logic [IQ_WIDTH:0] mag;
  logic bit_s, erase, take, last, push, pop, full, empty, unused_hi;
  logic [OUT_WIDTH-1:0] sr_q, sr_d, word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, ready_q, ready_d;
  logic [15:0] ecnt_q, ecnt_d;
  assign i_s       = signal_in[I_LSB +: IQ_WIDTH];
  assign unused_hi = ^signal_in[31:I_LSB+IQ_WIDTH];
  // one extra bit so the most negative I has a representable magnitude
  assign i_x   = {i_s[IQ_WIDTH-1], i_s};
  assign mag   = i_x[IQ_WIDTH] ? -i_x : i_x;
  assign erase = mag < TH;
  assign bit_s = i_s[IQ_WIDTH-1];
  assign take  = signal_valid & ~clear;
  assign last  = cnt_q == CW'(OUT_WIDTH-1);
  assign word  = (LSB_FIRST != 0) ? {bit_s, sr_q[OUT_WIDTH-1:1]} : {sr_q[OUT_WIDTH-2:0], bit_s};
  assign push  = take & last;
  assign pop   = data_valid & data_ready & ~clear;
  always_comb begin
    sr_d    = clear ? '0 : take ? word : sr_q;
    cnt_d   = clear ? '0 : take ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    ovf_d   = clear ? 1'b0 : ovf_q | (push & full & ~pop);
    ecnt_d  = clear ? 16'd0 : (take & erase & ~&ecnt_q) ? ecnt_q + 16'd1 : ecnt_q;
    ready_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ecnt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ecnt_q  <= ecnt_d;
      ready_q <= ready_d;
    end
  end
  qam_demod_fifo #(.W(OUT_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (data_out),
    .full  (full),
    .empty (empty)
  );
  assign data_valid    = ~empty;
  assign overflow      = ovf_q;
  assign erasure_count = ecnt_q;
  assign ready         = ready_q;
endmodule

// File: tb/tb_qam_2_demod.sv
// tb_qam_2_demod: randomized and directed checks of MSB-first and LSB-first demappers against a queue-based model
module tb_qam_2_demod;
  import qam_pkg::*;
  logic clk = 0, rst = 0, clear = 0, signal_valid = 0, data_ready = 0;
  logic [31:0] signal_in = 0;
  logic [7:0] do0, do1;
  logic dv0, dv1, ov0, ov1, rd0, rd1;
  logic [15:0] ec0, ec1;
  int checks = 0, passed = 0;

  qam_2_demod #(.IQ_WIDTH(12), .OUT_WIDTH(8), .LSB_FIRST(0), .THRESH(2)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .signal_in(signal_in), .signal_valid(signal_valid),
    .data_out(do0), .data_valid(dv0), .data_ready(data_ready), .overflow(ov0),
    .erasure_count(ec0), .ready(rd0));
  qam_2_demod #(.IQ_WIDTH(12), .OUT_WIDTH(8), .LSB_FIRST(1), .THRESH(2)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .signal_in(signal_in), .signal_valid(signal_valid),
    .data_out(do1), .data_valid(dv1), .data_ready(data_ready), .overflow(ov1),
    .erasure_count(ec1), .ready(rd1));

  always #5 clk = ~clk;

  // model: received bits, buffered words (first bit in MSB), sticky flags
  bit m_bits[$];
  logic [7:0] m_fifo[$];
  bit m_ovf, m_rdy;
  int m_ec;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h at %0t", n, act, exp, $time);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_fifo.delete();
    m_ovf = 0;
    m_rdy = 0;
    m_ec  = 0;
  endtask

  task automatic model_edge();
    int iv;
    logic [7:0] w;
    bit pop;
    if (!rst) return;
    m_rdy = 1;
    pop = m_fifo.size() > 0 && data_ready;
    if (clear) begin
      m_bits.delete();
      m_fifo.delete();
      m_ovf = 0;
      m_ec  = 0;
      return;
    end
    if (pop) void'(m_fifo.pop_front());
    if (signal_valid) begin
      iv = int'(signal_in[11:0]);
      if (iv >= 2048) iv -= 4096;
      if ((iv < 0 ? -iv : iv) < 2 && m_ec < 65535) m_ec++;
      m_bits.push_back(iv < 0);
      if (m_bits.size() == 8) begin
        w = 0;
        for (int k = 0; k < 8; k++) w = {w[6:0], m_bits[k]};
        m_bits.delete();
        if (m_fifo.size() < 2) m_fifo.push_back(w);
        else m_ovf = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    chk("valid0", dv0, m_fifo.size() > 0);
    chk("valid1", dv1, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("data0", do0, m_fifo[0]);
      chk("data1", do1, rev8(m_fifo[0]));
    end
    chk("ovf0", ov0, m_ovf);
    chk("ovf1", ov1, m_ovf);
    chk("ecnt0", ec0, m_ec);
    chk("ecnt1", ec1, m_ec);
    chk("ready0", rd0, m_rdy);
    chk("ready1", rd1, m_rdy);
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drive(input bit v, input logic [11:0] i);
    signal_valid = v;
    signal_in = {20'($urandom()), i};
  endtask

  task automatic sample(input logic [11:0] i);
    drive(1, i);
    cyc();
  endtask

  task automatic do_clear();
    clear = 1;
    drive(1, 12'($urandom()));
    cyc();
    clear = 0;
    drive(0, 0);
  endtask

  function automatic logic [11:0] pick();
    logic [11:0] tbl[8];
    tbl = '{12'h000, 12'h001, 12'hFFF, 12'hFFE, 12'h800, 12'h7FF, 12'h002, 12'h003};
    return ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 7)] : 12'($urandom());
  endfunction

  initial begin
    logic [11:0] seq[8];
    seq = '{QAM2_NEG[11:0], QAM2_POS[11:0], QAM2_NEG[11:0], QAM2_POS[11:0],
            QAM2_POS[11:0], QAM2_POS[11:0], QAM2_POS[11:0], QAM2_NEG[11:0]};
    model_reset();
    repeat (3) cyc();
    chk("rst_data", do0, 8'h00);
    chk("rst_ready", rd0, 1'b0);
    chk("rst_valid", dv0, 1'b0);
    rst = 1;
    cyc();
    chk("ready_up", rd0, 1'b1);
    data_ready = 1;
    for (int k = 0; k < 8; k++) sample(seq[k]);
    chk("a1_msb", do0, 8'hA1);
    chk("a1_lsb", do1, 8'h85);
    chk("a1_valid", dv0, 1'b1);
    drive(0, 0);
    cyc();
    chk("a1_one_cycle", dv0, 1'b0);
    do_clear();
    sample(12'h000); sample(12'h001); sample(12'hFFF); sample(12'h800);
    chk("ecnt3", ec0, 16'd3);
    repeat (4) sample(12'h000);
    chk("erase_word_msb", do0, 8'h30);
    chk("erase_word_lsb", do1, 8'h0C);
    repeat (69996) sample(12'h000);
    chk("ecnt_sat", ec0, 16'hFFFF);
    do_clear();
    data_ready = 0;
    repeat (24) sample(pick());
    chk("ovf_set", ov0, 1'b1);
    chk("ovf_buffered", dv0, 1'b1);
    drive(0, 0);
    data_ready = 1;
    repeat (3) cyc();
    do_clear();
    data_ready = 0;
    repeat (23) sample(pick());
    data_ready = 1;
    sample(pick());
    chk("no_ovf_pop", ov0, 1'b0);
    drive(0, 0);
    repeat (3) cyc();
    data_ready = 0;
    repeat (13) sample(pick());
    do_clear();
    chk("clr_empty", dv0, 1'b0);
    chk("clr_ovf", ov0, 1'b0);
    data_ready = 1;
    repeat (8) sample(pick());
    drive(0, 0);
    cyc();
    data_ready = 0;
    repeat (11) sample(pick());
    rst = 0;
    model_reset();
    #1;
    chk("arst_valid", dv0, 1'b0);
    chk("arst_data", do0, 8'h00);
    chk("arst_ready", rd0, 1'b0);
    chk("arst_ecnt", ec0, 16'd0);
    repeat (2) sample(pick());
    rst = 1;
    data_ready = 1;
    repeat (9) sample(pick());
    repeat (3000) begin
      data_ready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 499) == 0) begin
        rst = 0;
        model_reset();
      end else rst = 1;
      drive($urandom_range(0, 3) != 0, pick());
      cyc();
    end
    clear = 0;
    rst = 1;
    drive(0, 0);
    cyc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
